// File: rtl/iob_ram_sp_be_arbiter_pkg.sv
// Shared defaults and encodings for the two-requester
// byte-enable single-port RAM arbiter.
package iob_ram_sp_be_arbiter_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam bit CLEAR_DEF  = 1'b1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  typedef enum logic {
    OWN_R0 = 1'b0,
    OWN_R1 = 1'b1
  } owner_t;

  function automatic owner_t owner_of(
    input logic [1:0] gnt
  );
    return gnt[1] ? OWN_R1 : OWN_R0;
  endfunction

endpackage

// File: rtl/iob_rr_arb_2.sv
// Two-input round-robin grant with a registered priority pointer.
// Ports: clk_i, rst_i, req[1:0], advance -> gnt[1:0] (one-hot or zero).
module iob_rr_arb_2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // ptr = 0 favours requester 0 when both ask
  logic ptr;

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11) & ~ptr: gnt = 2'b01;
      (req == 2'b11) &  ptr: gnt = 2'b10;
      (req == 2'b01):        gnt = 2'b01;
      (req == 2'b10):        gnt = 2'b10;
      default:               gnt = 2'b00;
    endcase
  end

  // after a grant the other side gets priority
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr <= 1'b0;
    end else if (advance & (|gnt)) begin
      ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/iob_ram_sp_be_arbiter.sv
// Round-robin share of one byte-enable SP RAM between r0/r1,
// with read-response routing and optional post-reset zero-fill.
// Ports: clk_i, rst_i, busy_o; rN_valid/addr/wdata/wstrb in,
// rN_ready/rvalid/rdata out; ram_en/we/addr/d out, ram_d_i in.
module iob_ram_sp_be_arbiter
  import iob_ram_sp_be_arbiter_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter bit CLEAR_ON_RESET = CLEAR_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic                busy_o,

  input  logic                r0_valid_i,
  input  logic [ADDR_W-1:0]   r0_addr_i,
  input  logic [DATA_W-1:0]   r0_wdata_i,
  input  logic [DATA_W/8-1:0] r0_wstrb_i,
  output logic                r0_ready_o,
  output logic                r0_rvalid_o,
  output logic [DATA_W-1:0]   r0_rdata_o,

  input  logic                r1_valid_i,
  input  logic [ADDR_W-1:0]   r1_addr_i,
  input  logic [DATA_W-1:0]   r1_wdata_i,
  input  logic [DATA_W/8-1:0] r1_wstrb_i,
  output logic                r1_ready_o,
  output logic                r1_rvalid_o,
  output logic [DATA_W-1:0]   r1_rdata_o,

  output logic                ram_en_o,
  output logic [DATA_W/8-1:0] ram_we_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [DATA_W-1:0]   ram_d_o,
  input  logic [DATA_W-1:0]   ram_d_i
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              rd_pend;
  owner_t            rd_own;

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              xfer;
  logic              sel;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [NB-1:0]     w_wstrb;
  logic              w_rd;

  // requests are only seen once the fill is done
  assign req = {r1_valid_i, r0_valid_i}
             & {2{state == ST_IDLE}};

  iob_rr_arb_2 u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (req),
    .advance (xfer),
    .gnt     (gnt)
  );

  assign xfer    = |gnt;
  assign sel     = gnt[1];
  assign w_addr  = sel ? r1_addr_i  : r0_addr_i;
  assign w_wdata = sel ? r1_wdata_i : r0_wdata_i;
  assign w_wstrb = sel ? r1_wstrb_i : r0_wstrb_i;
  assign w_rd    = ~|w_wstrb;

  assign r0_ready_o = gnt[0];
  assign r1_ready_o = gnt[1];

  always_comb begin
    ram_en_o   = 1'b0;
    ram_we_o   = '0;
    ram_addr_o = w_addr;
    ram_d_o    = w_wdata;
    unique case (1'b1)
      state == ST_INIT: begin
        ram_en_o   = 1'b1;
        ram_we_o   = '1;
        ram_addr_o = cnt;
        ram_d_o    = '0;
      end
      xfer: begin
        ram_en_o = 1'b1;
        ram_we_o = w_wstrb;
      end
      default: begin
        ram_en_o = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
      busy_o  <= CLEAR_ON_RESET;
      cnt     <= '0;
      rd_pend <= 1'b0;
      rd_own  <= OWN_R0;
    end else begin
      rd_pend <= xfer & w_rd;
      if (xfer) begin
        rd_own <= owner_of(gnt);
      end
      unique case (state)
        ST_INIT: begin
          cnt <= cnt + ADDR_W'(1);
          if (cnt == LAST) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // a reset arriving the cycle after a read kills its response
  assign r0_rvalid_o = rd_pend & ~rst_i & (rd_own == OWN_R0);
  assign r1_rvalid_o = rd_pend & ~rst_i & (rd_own == OWN_R1);
  assign r0_rdata_o  = ram_d_i;
  assign r1_rdata_o  = ram_d_i;

endmodule

// File: tb/tb_iob_ram_sp_be_arbiter.sv
// Scoreboard bench for iob_ram_sp_be_arbiter with a behavioural
// RAM, a high-level arbitration/memory model and a response monitor.
module tb_iob_ram_sp_be_arbiter;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          busy;
  logic          r0_valid, r1_valid;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic [NB-1:0] r0_wstrb, r1_wstrb;
  logic          r0_ready, r1_ready;
  logic          r0_rvalid, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          ram_en;
  logic [NB-1:0] ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_d, ram_q;

  logic          busy2;
  logic          r0_valid2;
  logic [AW-1:0] r0_addr2;
  logic [DW-1:0] r0_wdata2;
  logic [NB-1:0] r0_wstrb2;
  logic          r0_ready2, r1_ready2;
  logic          r0_rvalid2, r1_rvalid2;
  logic [DW-1:0] r0_rdata2, r1_rdata2;
  logic          ram_en2;
  logic [NB-1:0] ram_we2;
  logic [AW-1:0] ram_addr2;
  logic [DW-1:0] ram_d2;
  logic [DW-1:0] ram_q2;

  iob_ram_sp_be_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .busy_o(busy),
    .r0_valid_i(r0_valid), .r0_addr_i(r0_addr),
    .r0_wdata_i(r0_wdata), .r0_wstrb_i(r0_wstrb),
    .r0_ready_o(r0_ready), .r0_rvalid_o(r0_rvalid),
    .r0_rdata_o(r0_rdata),
    .r1_valid_i(r1_valid), .r1_addr_i(r1_addr),
    .r1_wdata_i(r1_wdata), .r1_wstrb_i(r1_wstrb),
    .r1_ready_o(r1_ready), .r1_rvalid_o(r1_rvalid),
    .r1_rdata_o(r1_rdata),
    .ram_en_o(ram_en), .ram_we_o(ram_we),
    .ram_addr_o(ram_addr), .ram_d_o(ram_d),
    .ram_d_i(ram_q)
  );

  iob_ram_sp_be_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1'b0)
  ) dut2 (
    .clk_i(clk), .rst_i(rst), .busy_o(busy2),
    .r0_valid_i(r0_valid2), .r0_addr_i(r0_addr2),
    .r0_wdata_i(r0_wdata2), .r0_wstrb_i(r0_wstrb2),
    .r0_ready_o(r0_ready2), .r0_rvalid_o(r0_rvalid2),
    .r0_rdata_o(r0_rdata2),
    .r1_valid_i(1'b0), .r1_addr_i('0),
    .r1_wdata_i('0), .r1_wstrb_i('0),
    .r1_ready_o(r1_ready2), .r1_rvalid_o(r1_rvalid2),
    .r1_rdata_o(r1_rdata2),
    .ram_en_o(ram_en2), .ram_we_o(ram_we2),
    .ram_addr_o(ram_addr2), .ram_d_o(ram_d2),
    .ram_d_i(ram_q2)
  );

  assign ram_q2 = '0;

  // behavioural byte-enable RAM, 1-cycle read latency
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < NB; b++)
        if (ram_we[b]) ram[ram_addr][8*b +: 8] <= ram_d[8*b +: 8];
      ram_q <= ram[ram_addr];
    end
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          v;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [NB-1:0] wstrb;
  } req_t;

  typedef struct {
    int          cyc;
    int          own;
    logic [DW-1:0] data;
  } exp_t;

  req_t rq [2];
  exp_t expq [$];
  logic [DW-1:0] mmem [DEPTH];
  int ptr;
  int init_left;
  bit chk2;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               name, act, want, cyc);
    end
  endtask

  task automatic drive();
    r0_valid = rq[0].v;  r1_valid = rq[1].v;
    r0_addr  = rq[0].addr;  r1_addr  = rq[1].addr;
    r0_wdata = rq[0].wdata; r1_wdata = rq[1].wdata;
    r0_wstrb = rq[0].wstrb; r1_wstrb = rq[1].wstrb;
  endtask

  // one clock: drive, check at negedge, update model
  task automatic step();
    int w;
    drive();
    @(negedge clk);
    if (rst) begin
      chk("rvalid_in_rst", {r1_rvalid, r0_rvalid}, 0);
    end else if (init_left > 0) begin
      chk("busy_init", busy, 1);
      chk("en_init", ram_en, 1);
      chk("we_init", ram_we, 4'hF);
      chk("addr_init", ram_addr, DEPTH - init_left);
      chk("d_init", ram_d, 0);
      chk("rdy_init", {r1_ready, r0_ready}, 0);
      init_left--;
    end else begin
      w = -1;
      if (rq[0].v && rq[1].v) w = ptr;
      else if (rq[0].v) w = 0;
      else if (rq[1].v) w = 1;
      chk("busy", busy, 0);
      chk("rdy0", r0_ready, w == 0);
      chk("rdy1", r1_ready, w == 1);
      chk("ram_en", ram_en, w >= 0);
      if (w >= 0) begin
        chk("ram_we", ram_we, rq[w].wstrb);
        chk("ram_addr", ram_addr, rq[w].addr);
        if (rq[w].wstrb == 0) begin
          expq.push_back('{cyc + 1, w, mmem[rq[w].addr]});
        end else begin
          chk("ram_d", ram_d, rq[w].wdata);
          for (int b = 0; b < NB; b++)
            if (rq[w].wstrb[b])
              mmem[rq[w].addr][8*b +: 8] = rq[w].wdata[8*b +: 8];
        end
        ptr = 1 - w;
        rq[w].v = 1'b0;
      end else begin
        chk("ram_we_idle", ram_we, 0);
      end
    end
    if (chk2) begin
      chk("busy_noclr", busy2, 0);
      chk("rdy_noclr_first", r0_ready2, 1);
      chk2 = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    rq[0].v = 1'b0;
    rq[1].v = 1'b0;
    expq.delete();
    ptr = 0;
    init_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    for (int i = 0; i < n; i++) begin
      step();
      chk("busy_rst", busy, 1);
      chk("busy2_rst", busy2, 0);
    end
    rst = 1'b0;
  endtask

  task automatic drain(int maxn);
    int n;
    n = 0;
    while ((rq[0].v || rq[1].v) && n < maxn) begin
      step();
      n++;
    end
    if (rq[0].v || rq[1].v) chk("grant_timeout", 1, 0);
  endtask

  task automatic set_rq(int i, logic [AW-1:0] a,
                        logic [DW-1:0] d, logic [NB-1:0] s);
    rq[i].v = 1'b1;
    rq[i].addr = a;
    rq[i].wdata = d;
    rq[i].wstrb = s;
  endtask

  // response monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        e = expq.pop_front();
        chk("rvalid_owner", {r1_rvalid, r0_rvalid},
            e.own ? 2'b10 : 2'b01);
        chk("rdata", e.own ? r1_rdata : r0_rdata, e.data);
      end else if (r0_rvalid || r1_rvalid) begin
        chk("rvalid_spurious", {r1_rvalid, r0_rvalid}, 0);
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = $urandom | 32'h1;
    rq[0] = '{1'b0, '0, '0, '0};
    rq[1] = '{1'b0, '0, '0, '0};
    chk2 = 1'b0;
    r0_valid2 = 1'b1;
    r0_addr2 = 4'd3;
    r0_wdata2 = '0;
    r0_wstrb2 = '0;
    do_reset(3);

    // zero-fill with r0 already waiting on a read of addr 3
    chk2 = 1'b1;
    set_rq(0, 4'd3, 0, 0);
    drain(40);

    // single requester: full write, byte write, read back
    set_rq(0, 4'd5, 32'hDEADBEEF, 4'hF);
    drain(5);
    set_rq(0, 4'd5, 32'h00000011, 4'b0001);
    drain(5);
    set_rq(0, 4'd5, 0, 0);
    drain(5);
    step();
    step();

    // continuous contention
    for (int k = 0; k < 6; k++) begin
      set_rq(0, 4'd1, 0, 0);
      set_rq(1, 4'd2, 0, 0);
      step();
    end
    drain(5);
    step();

    // r1 write then r0 read of the same word
    set_rq(1, 4'd7, 32'h0000A5A5, 4'hF);
    step();
    set_rq(0, 4'd7, 0, 0);
    step();
    step();
    step();

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!rq[i].v && ($urandom % 3 != 0)) begin
          set_rq(i, AW'($urandom_range(0, DEPTH - 1)),
                 $urandom,
                 ($urandom % 2) ? NB'(0)
                                : NB'($urandom_range(1, 15)));
        end
      end
      step();
    end
    drain(10);
    step();
    step();

    // reset the cycle after a granted r1 read
    set_rq(1, 4'd2, 0, 0);
    drain(5);
    do_reset(2);
    set_rq(0, 4'd4, 0, 0);
    set_rq(1, 4'd6, 0, 0);
    drain(40);
    step();
    step();

    chk("queue_empty", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
